io_out_arbiter: RTL and testbench

Round-robin arbiter that shares the single byte-wide debug IO output channel between up to four requesters (CPU core, loader, debug monitor). Each requester presents a valid/ready byte stream with a last flag. A granted requester keeps the channel for a whole burst. One registered output stage drives the channel toward the IO controller's `io_out_*` port.

---
 rtl/io_out_arbiter.sv | 204 ++++++++++++++++++++
 tb/tb_io_out_arbiter.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/io_out_arbiter.sv
// Round-robin arbiter sharing the byte-wide debug IO output among NREQ burst requesters.
// Optional idle-burst watchdog enabled by defining IO_ARB_TIMEOUT_EN.
module io_out_arbiter #(
    parameter int NREQ      = 2,
    parameter int MAX_BURST = 16,
    parameter int TIMEOUT   = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [8*NREQ-1:0] req_data,
    input  logic [NREQ-1:0]   req_vld,
    input  logic [NREQ-1:0]   req_last,
    output logic [NREQ-1:0]   req_rdy,
    output logic [7:0]        io_out_data,
    output logic              io_out_vld,
    input  logic              io_out_rdy,
    output logic [NREQ-1:0]   grant,
    output logic              busy,
    output logic [NREQ-1:0]   io_err
);

    localparam int IW = (NREQ > 2) ? 2 : 1;
    localparam logic [7:0] CNT_LAST = 8'(MAX_BURST - 1);

    typedef enum logic {
        IDLE,
        BUSY
    } state_e;

    state_e          state_q, state_d;
    logic [IW-1:0]   g_q, g_d;
    logic [IW-1:0]   ptr_q, ptr_d;
    logic [7:0]      cnt_q, cnt_d;
    logic [NREQ-1:0] grant_q, grant_d;
    logic [7:0]      data_q, data_d;
    logic            vld_q, vld_d;

    logic [7:0]      g_byte;
    logic            g_vld;
    logic            g_last;
    logic            pick_found;
    logic [IW-1:0]   pick_idx;
    logic            out_free;
    logic            xfer;
    logic            rel;
    logic            tmo;

    function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] i);
        if (int'(i) == NREQ - 1) begin
            return '0;
        end
        return i + IW'(1);
    endfunction

    // Mux out the current owner's byte stream.
    always_comb begin
        g_byte = 8'h00;
        g_vld  = 1'b0;
        g_last = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (g_q == IW'(i)) begin
                g_byte = req_data[8*i +: 8];
                g_vld  = req_vld[i];
                g_last = req_last[i];
            end
        end
    end

    // First valid requester at or after ptr, wrapping around.
    always_comb begin : pick_c
        int j;
        j          = 0;
        pick_found = 1'b0;
        pick_idx   = '0;
        for (int k = 0; k < NREQ; k++) begin
            j = (int'(ptr_q) + k) % NREQ;
            if (!pick_found && req_vld[j]) begin
                pick_found = 1'b1;
                pick_idx   = IW'(j);
            end
        end
    end

`ifdef IO_ARB_TIMEOUT_EN
    logic [7:0]      wd_q, wd_d;
    logic [NREQ-1:0] err_q, err_d;

    assign tmo    = (state_q == BUSY) && (wd_q == 8'(TIMEOUT));
    assign io_err = err_q;
`else
    localparam int unused_timeout = TIMEOUT;

    assign tmo    = 1'b0;
    assign io_err = '0;
`endif

    assign out_free = ~vld_q | io_out_rdy;
    assign xfer     = (state_q == BUSY) & g_vld & out_free & ~tmo;
    assign rel      = xfer & (g_last | (cnt_q == CNT_LAST));

    always_comb begin
        req_rdy = '0;
        if (state_q == BUSY && !tmo) begin
            req_rdy[g_q] = g_vld & out_free;
        end
    end

    always_comb begin
        state_d = state_q;
        g_d     = g_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        grant_d = grant_q;
        data_d  = data_q;
        vld_d   = vld_q;
`ifdef IO_ARB_TIMEOUT_EN
        wd_d    = wd_q;
        err_d   = err_q;
`endif

        // Output stage drains on its own, whatever the arbiter state.
        if (xfer) begin
            data_d = g_byte;
            vld_d  = 1'b1;
        end else if (io_out_rdy) begin
            vld_d  = 1'b0;
        end

        unique case (state_q)
            IDLE: begin
                if (pick_found) begin
                    state_d           = BUSY;
                    g_d               = pick_idx;
                    cnt_d             = 8'h00;
                    grant_d           = '0;
                    grant_d[pick_idx] = 1'b1;
`ifdef IO_ARB_TIMEOUT_EN
                    wd_d              = 8'h00;
`endif
                end
            end
            BUSY: begin
`ifdef IO_ARB_TIMEOUT_EN
                if (tmo) begin
                    err_d[g_q] = 1'b1;
                    state_d    = IDLE;
                    ptr_d      = next_idx(g_q);
                    grant_d    = '0;
                end else if (!g_vld) begin
                    wd_d = wd_q + 8'd1;
                end else if (xfer) begin
                    wd_d = 8'h00;
                end
`endif
                if (xfer) begin
                    cnt_d = cnt_q + 8'd1;
                end
                if (rel) begin
                    state_d = IDLE;
                    ptr_d   = next_idx(g_q);
                    grant_d = '0;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            g_q     <= '0;
            ptr_q   <= '0;
            cnt_q   <= 8'h00;
            grant_q <= '0;
            data_q  <= 8'h00;
            vld_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            g_q     <= g_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            grant_q <= grant_d;
            data_q  <= data_d;
            vld_q   <= vld_d;
        end
    end

`ifdef IO_ARB_TIMEOUT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wd_q  <= 8'h00;
            err_q <= '0;
        end else begin
            wd_q  <= wd_d;
            err_q <= err_d;
        end
    end
`endif

    assign io_out_data = data_q;
    assign io_out_vld  = vld_q;
    assign grant       = grant_q;
    assign busy        = (state_q == BUSY);

endmodule

// File: tb/tb_io_out_arbiter.sv
// Directed bench for io_out_arbiter: per-cycle vector table plus scoreboarded
// sequences for round-robin, burst limit, watchdog and async reset.
module tb_io_out_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] req_data;
    logic [1:0]  req_vld;
    logic [1:0]  req_last;
    logic [1:0]  req_rdy;
    logic [7:0]  io_out_data;
    logic        io_out_vld;
    logic        io_out_rdy;
    logic [1:0]  grant;
    logic        busy;
    logic [1:0]  io_err;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    io_out_arbiter #(
        .NREQ     (2),
        .MAX_BURST(4),
        .TIMEOUT  (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_data   (req_data),
        .req_vld    (req_vld),
        .req_last   (req_last),
        .req_rdy    (req_rdy),
        .io_out_data(io_out_data),
        .io_out_vld (io_out_vld),
        .io_out_rdy (io_out_rdy),
        .grant      (grant),
        .busy       (busy),
        .io_err     (io_err)
    );

    typedef struct {
        logic [1:0] vld;
        logic [1:0] last;
        logic [7:0] d0;
        logic [7:0] d1;
        logic       ordy;
        logic [1:0] erdy;
        logic       eov;
        logic [7:0] eod;
        logic [1:0] egnt;
        logic       ebusy;
    } vec_t;

    vec_t vt[22];

    logic [8:0] q0[$];
    logic [8:0] q1[$];
    logic [7:0] got[$];
    int         stamp[$];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_seq(input string name, input logic [7:0] exp[$]);
        check({name, ".len"}, 32'(got.size()), 32'(exp.size()));
        for (int i = 0; i < exp.size() && i < got.size(); i++) begin
            check($sformatf("%s[%0d]", name, i), 32'(got[i]), 32'(exp[i]));
        end
    endtask

    task automatic drive_idle();
        req_vld    = 2'b00;
        req_last   = 2'b00;
        req_data   = 16'h0000;
        io_out_rdy = 1'b1;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        drive_idle();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Requesters pop their queue head when accepted; outputs are logged with cycle index.
    task automatic run_seq(input int ncyc, input int st0, input int st1);
        bit a0;
        bit a1;
        a0 = 1'b0;
        a1 = 1'b0;
        got.delete();
        stamp.delete();
        for (int k = 0; k < ncyc; k++) begin
            @(posedge clk);
            #1;
            if (a0) void'(q0.pop_front());
            if (a1) void'(q1.pop_front());
            req_vld[0]     = (k >= st0) && (q0.size() != 0);
            req_vld[1]     = (k >= st1) && (q1.size() != 0);
            req_data[7:0]  = req_vld[0] ? q0[0][7:0] : 8'h00;
            req_last[0]    = req_vld[0] ? q0[0][8] : 1'b0;
            req_data[15:8] = req_vld[1] ? q1[0][7:0] : 8'h00;
            req_last[1]    = req_vld[1] ? q1[0][8] : 1'b0;
            @(negedge clk);
            a0 = req_vld[0] & req_rdy[0];
            a1 = req_vld[1] & req_rdy[1];
            if (io_out_vld && io_out_rdy) begin
                got.push_back(io_out_data);
                stamp.push_back(k);
            end
        end
        @(posedge clk);
        #1;
        if (a0) void'(q0.pop_front());
        if (a1) void'(q1.pop_front());
        drive_idle();
    endtask

    initial begin
        logic [7:0] exp[$];

        rst = 1'b1;
        drive_idle();

        // vld last d0 d1 ordy | req_rdy out_vld out_data grant busy
        vt[0]  = '{2'b01, 2'b00, 8'h41, 8'h00, 1'b1, 2'b00, 1'b0, 8'h00, 2'b00, 1'b0};
        vt[1]  = '{2'b01, 2'b00, 8'h41, 8'h00, 1'b1, 2'b01, 1'b0, 8'h00, 2'b01, 1'b1};
        vt[2]  = '{2'b01, 2'b00, 8'h42, 8'h00, 1'b1, 2'b01, 1'b1, 8'h41, 2'b01, 1'b1};
        vt[3]  = '{2'b01, 2'b01, 8'h43, 8'h00, 1'b1, 2'b01, 1'b1, 8'h42, 2'b01, 1'b1};
        vt[4]  = '{2'b00, 2'b00, 8'h00, 8'h00, 1'b1, 2'b00, 1'b1, 8'h43, 2'b00, 1'b0};
        vt[5]  = '{2'b00, 2'b00, 8'h00, 8'h00, 1'b1, 2'b00, 1'b0, 8'h43, 2'b00, 1'b0};
        vt[6]  = '{2'b11, 2'b11, 8'h50, 8'h60, 1'b1, 2'b00, 1'b0, 8'h43, 2'b00, 1'b0};
        vt[7]  = '{2'b11, 2'b11, 8'h50, 8'h60, 1'b1, 2'b10, 1'b0, 8'h43, 2'b10, 1'b1};
        vt[8]  = '{2'b01, 2'b01, 8'h50, 8'h00, 1'b1, 2'b00, 1'b1, 8'h60, 2'b00, 1'b0};
        vt[9]  = '{2'b01, 2'b01, 8'h50, 8'h00, 1'b1, 2'b01, 1'b0, 8'h60, 2'b01, 1'b1};
        vt[10] = '{2'b00, 2'b00, 8'h00, 8'h00, 1'b1, 2'b00, 1'b1, 8'h50, 2'b00, 1'b0};
        vt[11] = '{2'b01, 2'b00, 8'h71, 8'h00, 1'b1, 2'b00, 1'b0, 8'h50, 2'b00, 1'b0};
        vt[12] = '{2'b01, 2'b00, 8'h71, 8'h00, 1'b1, 2'b01, 1'b0, 8'h50, 2'b01, 1'b1};
        for (int i = 13; i < 18; i++) begin
            vt[i] = '{2'b01, 2'b00, 8'h72, 8'h00, 1'b0, 2'b00, 1'b1, 8'h71, 2'b01, 1'b1};
        end
        vt[18] = '{2'b01, 2'b00, 8'h72, 8'h00, 1'b1, 2'b01, 1'b1, 8'h71, 2'b01, 1'b1};
        vt[19] = '{2'b01, 2'b01, 8'h73, 8'h00, 1'b1, 2'b01, 1'b1, 8'h72, 2'b01, 1'b1};
        vt[20] = '{2'b00, 2'b00, 8'h00, 8'h00, 1'b1, 2'b00, 1'b1, 8'h73, 2'b00, 1'b0};
        vt[21] = '{2'b00, 2'b00, 8'h00, 8'h00, 1'b1, 2'b00, 1'b0, 8'h73, 2'b00, 1'b0};

        do_reset();
        for (int i = 0; i < 22; i++) begin
            @(posedge clk);
            #1;
            req_vld    = vt[i].vld;
            req_last   = vt[i].last;
            req_data   = {vt[i].d1, vt[i].d0};
            io_out_rdy = vt[i].ordy;
            @(negedge clk);
            check($sformatf("v%0d.req_rdy", i), 32'(req_rdy), 32'(vt[i].erdy));
            check($sformatf("v%0d.out_vld", i), 32'(io_out_vld), 32'(vt[i].eov));
            check($sformatf("v%0d.out_data", i), 32'(io_out_data), 32'(vt[i].eod));
            check($sformatf("v%0d.grant", i), 32'(grant), 32'(vt[i].egnt));
            check($sformatf("v%0d.busy", i), 32'(busy), 32'(vt[i].ebusy));
            check($sformatf("v%0d.io_err", i), 32'(io_err), 32'h0);
        end

        // Round robin, single-byte bursts.
        do_reset();
        q0 = '{9'h1A0, 9'h1A1, 9'h1A2, 9'h1A3};
        q1 = '{9'h1B0, 9'h1B1, 9'h1B2, 9'h1B3};
        run_seq(24, 0, 0);
        exp = '{8'hA0, 8'hB0, 8'hA1, 8'hB1, 8'hA2, 8'hB2, 8'hA3, 8'hB3};
        check_seq("rr", exp);
        if (stamp.size() == 8) begin
            check("rr.first_cycle", 32'(stamp[0]), 32'd2);
            for (int i = 1; i < 8; i++) begin
                check($sformatf("rr.gap%0d", i), 32'(stamp[i] - stamp[i-1]), 32'd2);
            end
        end

        // Burst limit of 4 with requester 0 arriving mid-burst.
        q1 = '{9'h0C1, 9'h0C2, 9'h0C3, 9'h0C4, 9'h0C5,
               9'h0C6, 9'h0C7, 9'h0C8, 9'h0C9, 9'h0CA};
        q0 = '{9'h1D0};
        run_seq(24, 2, 0);
        exp = '{8'hC1, 8'hC2, 8'hC3, 8'hC4, 8'hD0, 8'hC5,
                8'hC6, 8'hC7, 8'hC8, 8'hC9, 8'hCA};
        check_seq("maxb", exp);
        if (stamp.size() == 11) begin
            check("maxb.d0_cycle", 32'(stamp[4]), 32'd7);
            check("maxb.c5_cycle", 32'(stamp[5]), 32'd9);
        end

        // Requester 0 stalls mid-burst with requester 1 waiting.
        do_reset();
        q0 = '{9'h0E1};
        q1 = '{9'h1F1};
        run_seq(24, 0, 3);
`ifdef IO_ARB_TIMEOUT_EN
        exp = '{8'hE1, 8'hF1};
        check_seq("tmo", exp);
        if (stamp.size() == 2) begin
            check("tmo.f1_cycle", 32'(stamp[1]), 32'd13);
        end
        check("tmo.io_err", 32'(io_err), 32'h1);
        check("tmo.busy", 32'(busy), 32'h0);
`else
        exp = '{8'hE1};
        check_seq("hold", exp);
        check("hold.grant", 32'(grant), 32'h1);
        check("hold.busy", 32'(busy), 32'h1);
        check("hold.io_err", 32'(io_err), 32'h0);
`endif

        // Asynchronous reset with a byte sitting in the output register.
        do_reset();
        req_vld        = 2'b10;
        req_data[15:8] = 8'h99;
        io_out_rdy     = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        check("ar.pre_vld", 32'(io_out_vld), 32'h1);
        check("ar.pre_data", 32'(io_out_data), 32'h99);
        io_out_rdy = 1'b1;
        req_vld    = 2'b11;
        #1;
        check("ar.pre_rdy", 32'(req_rdy), 32'h2);
        rst = 1'b1;
        #1;
        check("ar.grant", 32'(grant), 32'h0);
        check("ar.busy", 32'(busy), 32'h0);
        check("ar.out_vld", 32'(io_out_vld), 32'h0);
        check("ar.out_data", 32'(io_out_data), 32'h0);
        check("ar.req_rdy", 32'(req_rdy), 32'h0);
        check("ar.io_err", 32'(io_err), 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("ar.idle_grant", 32'(grant), 32'h0);
        @(posedge clk);
        @(negedge clk);
        check("ar.first_grant", 32'(grant), 32'h1);
        check("ar.first_rdy", 32'(req_rdy), 32'h1);

        drive_idle();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
